// File: rtl/alu_mem_datapath_if.sv
// rtl/alu_mem_datapath_if.sv - operand, memory and fetch bus of the execute/memory slice
interface alu_mem_datapath_if;
  logic [63:0] BusA;
  logic [63:0] BusB;
  logic [3:0]  ALUCtrl;
  logic [63:0] BusW;
  logic        Zero;
  logic [63:0] WriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [63:0] ReadData;
  logic [63:0] PC;
  logic [31:0] Instruction;
  logic        ImemWrite;
  logic [63:0] ImemWAddr;
  logic [31:0] ImemWData;

  // Core side: drives operands, controls and fetch address; observes results.
  modport master (
    output BusA, BusB, ALUCtrl, WriteData, MemoryRead, MemoryWrite,
    output PC, ImemWrite, ImemWAddr, ImemWData,
    input  BusW, Zero, ReadData, Instruction
  );

  // Datapath side.
  modport slave (
    input  BusA, BusB, ALUCtrl, WriteData, MemoryRead, MemoryWrite,
    input  PC, ImemWrite, ImemWAddr, ImemWData,
    output BusW, Zero, ReadData, Instruction
  );
endinterface

// File: rtl/alu_mem_datapath.sv
// rtl/alu_mem_datapath.sv - 64-bit ALU, byte-addressed data memory and instruction memory
module alu_mem_datapath #(
  parameter int DMEM_BYTES = 1024,
  parameter int IMEM_WORDS = 256
) (
  input  logic                CLK,
  input  logic                reset,
  alu_mem_datapath_if.slave   bus
);
  localparam int AW = $clog2(DMEM_BYTES);
  localparam int IW = $clog2(IMEM_WORDS);

  logic [7:0]  dmem [DMEM_BYTES];
  logic [31:0] imem [IMEM_WORDS];

  logic [63:0]   alu_res;
  logic [63:0]   rd_data;
  logic          dm_ok;
  logic [AW-1:0] dm_base;
  logic          im_ok;
  logic [IW-1:0] im_ridx;
  logic          im_wok;
  logic [IW-1:0] im_widx;
  logic          unused_low_bits;

  // ALU: wrap-around arithmetic; undefined codes yield zero so Zero reads as 1.
  always_comb begin
    alu_res = '0;
    case (bus.ALUCtrl)
      4'b0000: alu_res = bus.BusA & bus.BusB;
      4'b0001: alu_res = bus.BusA | bus.BusB;
      4'b0010: alu_res = bus.BusA + bus.BusB;
      4'b0110: alu_res = bus.BusA - bus.BusB;
      4'b0111: alu_res = bus.BusB;
      default: alu_res = '0;
    endcase
  end

  assign bus.BusW = alu_res;
  assign bus.Zero = (alu_res == 64'd0);

  // A doubleword access is legal only when all eight bytes fit in the array.
  assign dm_ok   = (alu_res <= 64'(DMEM_BYTES - 8));
  assign dm_base = alu_res[AW-1:0];

  // Word index comes from the byte address with the two low bits dropped.
  assign im_ok   = (bus.PC[63:2] < 62'(IMEM_WORDS));
  assign im_ridx = bus.PC[IW+1:2];
  assign im_wok  = (bus.ImemWAddr[63:2] < 62'(IMEM_WORDS));
  assign im_widx = bus.ImemWAddr[IW+1:2];

  assign unused_low_bits = ^{bus.PC[1:0], bus.ImemWAddr[1:0]};

  // Little-endian doubleword load from any byte alignment; zero when disabled or out of range.
  always_comb begin
    rd_data = '0;
    if (bus.MemoryRead && dm_ok) begin
      for (int i = 0; i < 8; i++) begin
        rd_data[i*8 +: 8] = dmem[dm_base + AW'(i)];
      end
    end
  end

  assign bus.ReadData    = rd_data;
  assign bus.Instruction = im_ok ? imem[im_ridx] : 32'd0;

  // Reset wipes both memories and beats any store or program load in the same cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int i = 0; i < DMEM_BYTES; i++) begin
        dmem[i] <= 8'd0;
      end
      for (int j = 0; j < IMEM_WORDS; j++) begin
        imem[j] <= 32'd0;
      end
    end else begin
      if (bus.MemoryWrite && dm_ok) begin
        for (int i = 0; i < 8; i++) begin
          dmem[dm_base + AW'(i)] <= bus.WriteData[i*8 +: 8];
        end
      end
      if (bus.ImemWrite && im_wok) begin
        imem[im_widx] <= bus.ImemWData;
      end
    end
  end
endmodule

// File: tb/tb_alu_mem_datapath.sv
// tb/tb_alu_mem_datapath.sv - directed checks of ALU, data memory, instruction memory and reset
module tb_alu_mem_datapath;
  logic CLK = 1'b0;
  logic reset;

  alu_mem_datapath_if bus();

  alu_mem_datapath #(.DMEM_BYTES(1024), .IMEM_WORDS(256)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] w;
    logic        z;
  } alu_vec_t;

  alu_vec_t vecs [10];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Put an address on BusW through ADD with B=0.
  task automatic set_addr(input logic [63:0] a);
    bus.ALUCtrl = 4'b0010;
    bus.BusA    = a;
    bus.BusB    = 64'd0;
    #1;
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d);
    set_addr(a);
    bus.WriteData   = d;
    bus.MemoryWrite = 1'b1;
    tick();
    bus.MemoryWrite = 1'b0;
    #1;
  endtask

  task automatic read_check(input string name, input logic [63:0] a, input logic [63:0] exp);
    set_addr(a);
    bus.MemoryRead = 1'b1;
    #1;
    check(name, bus.ReadData, exp);
  endtask

  task automatic imem_load(input logic [63:0] a, input logic [31:0] d);
    bus.ImemWAddr = a;
    bus.ImemWData = d;
    bus.ImemWrite = 1'b1;
    tick();
    bus.ImemWrite = 1'b0;
    #1;
  endtask

  task automatic fetch_check(input string name, input logic [63:0] pc, input logic [31:0] exp);
    bus.PC = pc;
    #1;
    check(name, 64'(bus.Instruction), 64'(exp));
  endtask

  initial begin
    vecs[0] = '{4'b0000, 64'hF0, 64'h3C, 64'h30, 1'b0};
    vecs[1] = '{4'b0001, 64'hF0, 64'h3C, 64'hFC, 1'b0};
    vecs[2] = '{4'b0010, 64'hF0, 64'h3C, 64'h12C, 1'b0};
    vecs[3] = '{4'b0110, 64'hF0, 64'h3C, 64'hB4, 1'b0};
    vecs[4] = '{4'b0111, 64'hF0, 64'h3C, 64'h3C, 1'b0};
    vecs[5] = '{4'b0110, 64'd5, 64'd5, 64'd0, 1'b1};
    vecs[6] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1};
    vecs[7] = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[8] = '{4'b1111, 64'hF0, 64'h3C, 64'd0, 1'b1};
    vecs[9] = '{4'b0011, 64'hF0, 64'h3C, 64'd0, 1'b1};

    reset           = 1'b1;
    bus.BusA        = '0;
    bus.BusB        = '0;
    bus.ALUCtrl     = '0;
    bus.WriteData   = '0;
    bus.MemoryRead  = 1'b0;
    bus.MemoryWrite = 1'b0;
    bus.PC          = '0;
    bus.ImemWrite   = 1'b0;
    bus.ImemWAddr   = '0;
    bus.ImemWData   = '0;
    tick();
    reset = 1'b0;
    #1;

    read_check("reset_dmem_0", 64'd0, 64'd0);
    read_check("reset_dmem_1016", 64'd1016, 64'd0);
    fetch_check("reset_imem_0", 64'd0, 32'd0);

    for (int i = 0; i < 10; i++) begin
      bus.ALUCtrl = vecs[i].ctrl;
      bus.BusA    = vecs[i].a;
      bus.BusB    = vecs[i].b;
      #2;
      check($sformatf("alu_w[%0d]", i), bus.BusW, vecs[i].w);
      check($sformatf("alu_z[%0d]", i), 64'(bus.Zero), 64'(vecs[i].z));
    end

    // Same-cycle read during a store shows the old contents.
    set_addr(64'd8);
    bus.MemoryRead  = 1'b1;
    bus.WriteData   = 64'h0123_4567_89AB_CDEF;
    bus.MemoryWrite = 1'b1;
    #1;
    check("rw_same_cycle_old", bus.ReadData, 64'd0);
    tick();
    bus.MemoryWrite = 1'b0;
    #1;
    check("rw_after_edge_new", bus.ReadData, 64'h0123_4567_89AB_CDEF);
    read_check("load_8", 64'd8, 64'h0123_4567_89AB_CDEF);
    check("byte_8", 64'(bus.ReadData[7:0]), 64'hEF);
    read_check("load_12_unaligned", 64'd12, 64'h0000_0000_0123_4567);
    bus.MemoryRead = 1'b0;
    #1;
    check("read_disabled", bus.ReadData, 64'd0);

    store(64'd1017, 64'hDEAD_BEEF_CAFE_F00D);
    read_check("oob_write_ignored", 64'd1016, 64'd0);
    read_check("oob_read_1017", 64'd1017, 64'd0);
    store(64'd1016, 64'h1122_3344_5566_7788);
    read_check("write_1016", 64'd1016, 64'h1122_3344_5566_7788);
    read_check("read_2000", 64'd2000, 64'd0);

    imem_load(64'd4, 32'h8B02_0020);
    imem_load(64'd8, 32'hF840_03E9);
    imem_load(64'd1024, 32'h1234_5678);
    fetch_check("imem_pc4", 64'd4, 32'h8B02_0020);
    fetch_check("imem_pc6", 64'd6, 32'h8B02_0020);
    fetch_check("imem_pc8", 64'd8, 32'hF840_03E9);
    fetch_check("imem_pc0", 64'd0, 32'd0);
    fetch_check("imem_pc4096", 64'd4096, 32'd0);
    fetch_check("imem_pc1020", 64'd1020, 32'd0);

    // Reset with a concurrent store: reset wins and everything reads zero.
    set_addr(64'd16);
    bus.WriteData   = 64'hA5A5_A5A5_A5A5_A5A5;
    bus.MemoryWrite = 1'b1;
    bus.ImemWAddr   = 64'd12;
    bus.ImemWData   = 32'hFFFF_FFFF;
    bus.ImemWrite   = 1'b1;
    reset           = 1'b1;
    tick();
    reset           = 1'b0;
    bus.MemoryWrite = 1'b0;
    bus.ImemWrite   = 1'b0;
    #1;
    read_check("rst_dmem_8", 64'd8, 64'd0);
    read_check("rst_dmem_16", 64'd16, 64'd0);
    read_check("rst_dmem_1016", 64'd1016, 64'd0);
    fetch_check("rst_imem_4", 64'd4, 32'd0);
    fetch_check("rst_imem_8", 64'd8, 32'd0);
    fetch_check("rst_imem_12", 64'd12, 32'd0);

    imem_load(64'd4, 32'h8B02_0020);
    fetch_check("reload_pc4", 64'd4, 32'h8B02_0020);
    store(64'd0, 64'h0000_0000_0000_0042);
    read_check("reload_dmem_0", 64'd0, 64'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_mem_datapath.md
# alu_mem_datapath

Combined execute/memory slice of the single-cycle 64-bit processor: a 64-bit ALU with zero flag, a byte-addressed 64-bit-wide data memory addressed by the ALU result, and a word-organised instruction memory indexed by the PC. All reads are combinational so one instruction can fetch, compute and read memory in one cycle. Writes and reset occur on the clock edge.

## Interface
- Clocking: one clock; reset is synchronous and active-high.
- Parameters:
  - DMEM_BYTES, 1024: data memory size in bytes.
  - IMEM_WORDS, 256: instruction memory size in 32-bit words.
- Ports:
  - CLK  in  1: clock; all state updates on rising edge.
  - reset  in  1: synchronous, active-high; clears both memories.
  - BusA  in  64: ALU operand A.
  - BusB  in  64: ALU operand B.
  - ALUCtrl  in  4: ALU operation select.
  - BusW  out  64: ALU result; also the data memory byte address.
  - Zero  out  1: 1 when BusW == 0.
  - WriteData  in  64: data memory store value.
  - MemoryRead  in  1: enables ReadData.
  - MemoryWrite  in  1: store enable.
  - ReadData  out  64: load value.
  - PC  in  64: instruction fetch address (byte address).
  - Instruction  out  32: fetched instruction.
  - ImemWrite  in  1: program-load enable.
  - ImemWAddr  in  64: program-load byte address.
  - ImemWData  in  32: program-load word.

## Operation
- ALU (combinational, 64-bit, wrap-around, no carry/overflow outputs):
  - 0000 AND: A & B.
  - 0001 OR: A | B.
  - 0010 ADD: A + B mod 2^64.
  - 0110 SUB: A - B mod 2^64.
  - 0111 PassB: B.
  - Any other code: BusW = 0, so Zero = 1.
- Data memory:
  - Byte array of DMEM_BYTES. A 64-bit access at address a covers bytes a..a+7, little-endian (byte a = bits 7:0). Any alignment is allowed.
  - Read: ReadData = assembled doubleword when MemoryRead=1 and a+7 < DMEM_BYTES; otherwise ReadData = 0.
  - Write: on the rising edge with MemoryWrite=1 and a+7 < DMEM_BYTES, store WriteData at bytes a..a+7. Out-of-range writes are ignored entirely; there are no partial writes.
- Instruction memory:
  - Array of IMEM_WORDS 32-bit words, indexed by PC[63:2]; PC[1:0] is ignored.
  - Instruction = word at index, or 0 if the index is >= IMEM_WORDS.
  - Load: on the rising edge with ImemWrite=1, store ImemWData at index ImemWAddr[63:2] if in range; otherwise ignore.
- Reset: on a rising edge with reset=1, every data memory byte and instruction word is cleared to 0. Reset overrides MemoryWrite and ImemWrite in the same cycle.

## Timing
- ALU, Zero, ReadData and Instruction are combinational from their inputs and current memory contents. Latency is 0 cycles.
- Stores and program loads take effect at the rising edge. A read of the same address in that cycle returns the old data before the edge and the new data after it.
- After reset: with MemoryRead=1, ReadData = 0 for every in-range address, and Instruction = 0 for every PC. BusW and Zero depend only on their inputs and are unaffected by reset.
- MemoryRead and MemoryWrite may both be 1 in the same cycle; the read shows the pre-edge contents.
- Reset asserted mid-program loses all memory contents; the bench must reload the program afterwards.

## Test plan
- ALU ops: A=0xF0, B=0x3C. Required: AND→0x30; OR→0xFC; ADD→0x12C; SUB→0xB4; PassB→0x3C. Then SUB with A=B=5 → BusW=0, Zero=1.
- Wrap-around: ADD 0xFFFF_FFFF_FFFF_FFFF+1 → 0 with Zero=1. SUB 0-1 → all ones with Zero=0. ALUCtrl=1111 → BusW=0.
- Store/load: store 0x0123456789ABCDEF at address 8 (A=8, B=0, ADD). Required: reads at 8 return it, byte 8 = 0xEF. Read at address 12 returns 0x0000_0000_0123_4567. MemoryRead=0 gives ReadData=0.
- Boundary: write at address 1017 is ignored. Address 1016 accepts the write and reads back. Reading at 2000 returns 0.
- Instruction memory: load 0x8B020020 at byte 4 and 0xF84003E9 at byte 8. Required: PC=4→0x8B020020, PC=6→0x8B020020, PC=8→0xF84003E9, PC=4096→0.
- Reset: after loading data and program, one reset cycle concurrent with MemoryWrite=1. Required: all reads return 0 and the concurrent write is discarded.
